// File: rtl/std_lane_pkg.sv
// Shared definitions for the STD-to-PE lane buffer: the cntl encodings and the
// framing state machine's state type and transition helpers.
package std_lane_pkg;

  localparam logic [1:0] STD_CNTL_MOD     = 2'b00;
  localparam logic [1:0] STD_CNTL_SOD     = 2'b01;
  localparam logic [1:0] STD_CNTL_EOD     = 2'b10;
  localparam logic [1:0] STD_CNTL_SOD_EOD = 2'b11;

  typedef enum logic {
    FRM_IDLE   = 1'b0,
    FRM_IN_MSG = 1'b1
  } frm_state_t;

  // An illegal beat still moves the FSM: SOD/SOD_EOD always restart the message.
  function automatic frm_state_t frm_next(input frm_state_t st, input logic [1:0] code);
    frm_state_t nxt;
    nxt = st;
    case (code)
      STD_CNTL_SOD:     nxt = FRM_IN_MSG;
      STD_CNTL_SOD_EOD: nxt = FRM_IDLE;
      STD_CNTL_EOD:     nxt = FRM_IDLE;
      default:          nxt = st;
    endcase
    return nxt;
  endfunction

  function automatic logic frm_is_err(input frm_state_t st, input logic [1:0] code);
    logic err;
    if (st == FRM_IDLE)
      err = (code == STD_CNTL_MOD) || (code == STD_CNTL_EOD);
    else
      err = (code == STD_CNTL_SOD) || (code == STD_CNTL_SOD_EOD);
    return err;
  endfunction

endpackage

// File: rtl/std_lane_strm_fifo.sv
// One stream of the lane buffer: skid FIFO with registered ready, framing
// checker on accepted beats, and sticky overflow/framing status.
// Handshake: a beat moves on the input side whenever in_valid is high and there
// is room (or a pop frees room the same cycle); it moves on the output side when
// out_valid && out_ready. in_ready is advisory flow control only.
module std_lane_strm_fifo
  import std_lane_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CNTL_W   = 2,
  parameter int DEPTH    = 4,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [CNTL_W-1:0]   in_cntl,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W-1:0]   in_mask,
  output logic                in_ready,
  output logic                out_valid,
  output logic [CNTL_W-1:0]   out_cntl,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W-1:0]   out_mask,
  input  logic                out_ready,
  input  logic                err_clear,
  output logic                err_overflow,
  output logic                err_framing,
  output logic [ERRCNT_W-1:0] err_framing_cnt,
  output logic                frm_state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] RDY_LIM  = (AW+1)'(DEPTH - 2);

  typedef struct packed {
    logic [CNTL_W-1:0] cntl;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
  } std_beat_t;

  std_beat_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  frm_state_t    frm_state;
  logic          full, push, pop, ovf_evt, frm_err;
  logic [1:0]    code;

  assign code      = in_cntl[1:0];
  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (~full | pop);
  assign ovf_evt   = in_valid & full & ~pop;
  assign frm_err   = push & frm_is_err(frm_state, code);

  assign out_cntl      = mem[rd_ptr].cntl;
  assign out_data      = mem[rd_ptr].data;
  assign out_mask      = mem[rd_ptr].mask;
  assign frm_state_dbg = (frm_state == FRM_IN_MSG);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cntl: in_cntl, data: in_data, mask: in_mask};
  end

  // Ready leaves one slot of skid for a sender that reacts a cycle late.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_ready  <= 1'b0;
      frm_state <= FRM_IDLE;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt <= RDY_LIM);
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        frm_state <= frm_next(frm_state, code);
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A new error in the clearing cycle survives the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow    <= 1'b0;
      err_framing     <= 1'b0;
      err_framing_cnt <= '0;
    end else if (err_clear) begin
      err_overflow    <= ovf_evt;
      err_framing     <= frm_err;
      err_framing_cnt <= {{(ERRCNT_W-1){1'b0}}, frm_err};
    end else begin
      err_overflow <= err_overflow | ovf_evt;
      err_framing  <= err_framing | frm_err;
      if (frm_err && !(&err_framing_cnt)) err_framing_cnt <= err_framing_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/std_pe_lane_buffer.sv
// Stack-bus downstream lane buffer: NUM_STRM independent stream FIFOs between
// the STD lane drivers and one PE lane's streaming-ops inputs.
module std_pe_lane_buffer
  import std_lane_pkg::*;
#(
  parameter int NUM_STRM = 2,
  parameter int DATA_W   = 32,
  parameter int CNTL_W   = 2,
  parameter int DEPTH    = 4,
  parameter int ERRCNT_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_STRM-1:0]          std__pe__lane_valid,
  input  logic [NUM_STRM*CNTL_W-1:0]   std__pe__lane_cntl,
  input  logic [NUM_STRM*DATA_W-1:0]   std__pe__lane_data,
  input  logic [NUM_STRM*DATA_W-1:0]   std__pe__lane_data_mask,
  output logic [NUM_STRM-1:0]          pe__std__lane_ready,
  output logic [NUM_STRM-1:0]          lane__pe__valid,
  output logic [NUM_STRM*CNTL_W-1:0]   lane__pe__cntl,
  output logic [NUM_STRM*DATA_W-1:0]   lane__pe__data,
  output logic [NUM_STRM*DATA_W-1:0]   lane__pe__data_mask,
  input  logic [NUM_STRM-1:0]          pe__lane__ready,
  input  logic                         err_clear,
  output logic [NUM_STRM-1:0]          err_overflow,
  output logic [NUM_STRM-1:0]          err_framing,
  output logic [NUM_STRM*ERRCNT_W-1:0] err_framing_cnt,
  output logic [NUM_STRM-1:0]          frm_state_dbg
);

  for (genvar s = 0; s < NUM_STRM; s++) begin : g_strm
    std_lane_strm_fifo #(
      .DATA_W   (DATA_W),
      .CNTL_W   (CNTL_W),
      .DEPTH    (DEPTH),
      .ERRCNT_W (ERRCNT_W)
    ) u_fifo (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (std__pe__lane_valid[s]),
      .in_cntl         (std__pe__lane_cntl[s*CNTL_W +: CNTL_W]),
      .in_data         (std__pe__lane_data[s*DATA_W +: DATA_W]),
      .in_mask         (std__pe__lane_data_mask[s*DATA_W +: DATA_W]),
      .in_ready        (pe__std__lane_ready[s]),
      .out_valid       (lane__pe__valid[s]),
      .out_cntl        (lane__pe__cntl[s*CNTL_W +: CNTL_W]),
      .out_data        (lane__pe__data[s*DATA_W +: DATA_W]),
      .out_mask        (lane__pe__data_mask[s*DATA_W +: DATA_W]),
      .out_ready       (pe__lane__ready[s]),
      .err_clear       (err_clear),
      .err_overflow    (err_overflow[s]),
      .err_framing     (err_framing[s]),
      .err_framing_cnt (err_framing_cnt[s*ERRCNT_W +: ERRCNT_W]),
      .frm_state_dbg   (frm_state_dbg[s])
    );
  end

endmodule

// File: tb/tb_std_pe_lane_buffer.sv
// Directed and random-traffic bench for std_pe_lane_buffer at NUM_STRM=2,
// DATA_W=32, DEPTH=4, ERRCNT_W=8.
module tb_std_pe_lane_buffer;

  localparam int BW = 2 + 32 + 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  lane_valid;
  logic [3:0]  lane_cntl;
  logic [63:0] lane_data;
  logic [63:0] lane_mask;
  logic [1:0]  std_ready;
  logic [1:0]  pe_valid;
  logic [3:0]  pe_cntl;
  logic [63:0] pe_data;
  logic [63:0] pe_mask;
  logic [1:0]  pe_ready;
  logic        err_clear;
  logic [1:0]  err_overflow;
  logic [1:0]  err_framing;
  logic [15:0] err_framing_cnt;
  logic [1:0]  frm_state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] exp_q [2][$];

  always #5 clk = ~clk;

  std_pe_lane_buffer dut (
    .clk                     (clk),
    .reset                   (reset),
    .std__pe__lane_valid     (lane_valid),
    .std__pe__lane_cntl      (lane_cntl),
    .std__pe__lane_data      (lane_data),
    .std__pe__lane_data_mask (lane_mask),
    .pe__std__lane_ready     (std_ready),
    .lane__pe__valid         (pe_valid),
    .lane__pe__cntl          (pe_cntl),
    .lane__pe__data          (pe_data),
    .lane__pe__data_mask     (pe_mask),
    .pe__lane__ready         (pe_ready),
    .err_clear               (err_clear),
    .err_overflow            (err_overflow),
    .err_framing             (err_framing),
    .err_framing_cnt         (err_framing_cnt),
    .frm_state_dbg           (frm_state_dbg)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int s, input logic v, input logic [1:0] c, input logic [31:0] d);
    lane_valid[s]        = v;
    lane_cntl[s*2 +: 2]  = c;
    lane_data[s*32 +: 32] = d;
    lane_mask[s*32 +: 32] = ~d;
  endtask

  task automatic idle_inputs();
    lane_valid = '0;
    lane_cntl  = '0;
    lane_data  = '0;
    lane_mask  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  int            mcount [2];
  int            sent [2];
  int            cyc;
  logic [1:0]    cc;
  logic [31:0]   dd;
  logic [BW-1:0] head;

  initial begin
    reset = 1'b1;
    err_clear = 1'b0;
    pe_ready = '0;
    idle_inputs();

    // Reset state, then ready on the first edge after reset falls
    cycle();
    cycle();
    check("rst_ready", std_ready, 2'b00);
    check("rst_valid", pe_valid, 2'b00);
    reset = 1'b0;
    cycle();
    check("post_rst_ready", std_ready, 2'b11);
    check("post_rst_valid", pe_valid, 2'b00);
    check("post_rst_err", {err_overflow, err_framing, err_framing_cnt}, '0);

    // Overflow: five beats into a four-deep FIFO with PE stalled
    for (int i = 0; i < 5; i++) begin
      set_beat(0, 1'b1, 2'b11, 32'hA0 + i);
      cycle();
      if (i == 0) check("ovf_first_data", pe_data[31:0], 32'hA0);
      if (i == 1) check("ovf_ready_b2", std_ready[0], 1'b1);
      if (i == 2) check("ovf_ready_b3", std_ready[0], 1'b0);
    end
    idle_inputs();
    check("ovf_flag", err_overflow, 2'b01);
    pe_ready = 2'b01;
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain_valid", pe_valid[0], 1'b1);
      check("ovf_drain_data", {pe_data[31:0], pe_mask[31:0]}, {32'hA0 + i, ~(32'hA0 + i)});
      cycle();
    end
    check("ovf_empty", pe_valid[0], 1'b0);
    check("ovf_ready_back", std_ready[0], 1'b1);

    // Full FIFO with simultaneous push and pop
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    check("clr_ovf", err_overflow, 2'b00);
    pe_ready = 2'b00;
    for (int i = 0; i < 4; i++) begin
      set_beat(0, 1'b1, 2'b11, 32'hB0 + i);
      cycle();
    end
    set_beat(0, 1'b1, 2'b11, 32'hB4);
    pe_ready = 2'b01;
    check("full_head", pe_data[31:0], 32'hB0);
    cycle();
    idle_inputs();
    check("full_no_ovf", err_overflow, 2'b00);
    check("full_ready", std_ready[0], 1'b0);
    for (int i = 1; i <= 4; i++) begin
      check("full_order", {pe_valid[0], pe_data[31:0]}, {1'b1, 32'hB0 + i});
      cycle();
    end
    check("full_empty", pe_valid[0], 1'b0);

    // Framing on stream 1: SOD MOD EOD MOD, then SOD SOD
    pe_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      cc = (i == 0) ? 2'b01 : (i == 2) ? 2'b10 : 2'b00;
      set_beat(1, 1'b1, cc, 32'hC0 + i);
      cycle();
      check("frm_fwd", {pe_valid[1], pe_cntl[3:2], pe_data[63:32]}, {1'b1, cc, 32'hC0 + i});
      if (i == 2) check("frm_ok_eod", err_framing, 2'b00);
    end
    check("frm_flag", err_framing, 2'b10);
    check("frm_cnt1", err_framing_cnt[15:8], 8'd1);
    set_beat(1, 1'b1, 2'b01, 32'hC4);
    cycle();
    set_beat(1, 1'b1, 2'b01, 32'hC5);
    cycle();
    check("frm_cnt2", err_framing_cnt[15:8], 8'd2);
    check("frm_state_in_msg", frm_state_dbg, 2'b10);
    set_beat(1, 1'b1, 2'b10, 32'hC6);
    cycle();
    check("frm_state_idle", frm_state_dbg, 2'b00);

    // Saturation, then err_clear racing a new error
    for (int i = 0; i < 300; i++) begin
      set_beat(1, 1'b1, 2'b00, 32'hD000 + i);
      cycle();
    end
    check("sat_cnt", err_framing_cnt[15:8], 8'd255);
    check("sat_no_ovf", err_overflow, 2'b00);
    set_beat(1, 1'b1, 2'b00, 32'hDEAD);
    err_clear = 1'b1;
    cycle();
    idle_inputs();
    check("clr_race", {err_framing, err_framing_cnt}, {2'b10, 16'h0100});
    cycle();
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    check("clr_all", {err_framing, err_framing_cnt}, '0);

    // Reset mid-message with three beats held
    pe_ready = 2'b00;
    cycle();
    set_beat(0, 1'b1, 2'b01, 32'hE0);
    cycle();
    set_beat(0, 1'b1, 2'b00, 32'hE1);
    cycle();
    set_beat(0, 1'b1, 2'b00, 32'hE2);
    cycle();
    idle_inputs();
    check("mid_valid", pe_valid, 2'b01);
    check("mid_state", frm_state_dbg, 2'b01);
    reset = 1'b1;
    cycle();
    check("mid_rst_valid", pe_valid, 2'b00);
    check("mid_rst_err", {err_overflow, err_framing, err_framing_cnt, frm_state_dbg}, '0);
    reset = 1'b0;
    cycle();
    check("mid_rst_ready", std_ready, 2'b11);

    // Random traffic on both streams, sender honours ready
    do_reset();
    for (int s = 0; s < 2; s++) begin
      mcount[s] = 0;
      sent[s] = 0;
    end
    cyc = 0;
    while (cyc < 20000 && (sent[0] < 1000 || sent[1] < 1000 ||
                           exp_q[0].size() != 0 || exp_q[1].size() != 0)) begin
      for (int s = 0; s < 2; s++) begin
        check("rnd_ready_rule", std_ready[s], (mcount[s] <= 2));
        check("rnd_valid", pe_valid[s], (mcount[s] != 0));
        pe_ready[s] = ($urandom_range(0, 1) == 1);
        if (pe_valid[s] && pe_ready[s]) begin
          check("rnd_sb_nonempty", (exp_q[s].size() != 0), 1'b1);
          if (exp_q[s].size() != 0) begin
            head = {pe_cntl[s*2 +: 2], pe_data[s*32 +: 32], pe_mask[s*32 +: 32]};
            check("rnd_beat", head, exp_q[s].pop_front());
          end
          mcount[s]--;
        end
        if (std_ready[s] && sent[s] < 1000 && $urandom_range(0, 9) < 7) begin
          cc = 2'($urandom_range(0, 3));
          dd = $urandom;
          lane_valid[s] = 1'b1;
          lane_cntl[s*2 +: 2] = cc;
          lane_data[s*32 +: 32] = dd;
          lane_mask[s*32 +: 32] = $urandom;
          exp_q[s].push_back({cc, dd, lane_mask[s*32 +: 32]});
          sent[s]++;
          mcount[s]++;
        end else begin
          lane_valid[s] = 1'b0;
        end
      end
      cycle();
      cyc++;
    end
    idle_inputs();
    check("rnd_sent0", sent[0], 1000);
    check("rnd_sent1", sent[1], 1000);
    check("rnd_drained0", exp_q[0].size(), 0);
    check("rnd_drained1", exp_q[1].size(), 0);
    check("rnd_no_ovf", err_overflow, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
